// File: rtl/receiver_if.sv
// Receive-side bus for the 8N1 UART receiver.
// Signals:
//   rx        serial line into the receiver, idle high
//   clken     single-cycle pulse at OVERSAMPLE x baud rate
//   rdy_clr   consumer acknowledge, clears rdy/overrun/frame_err
//   data      last good received byte
//   rdy       a byte is available in data
//   frame_err last frame had a low stop bit
//   overrun   a byte was committed while rdy was still set
//   rx_busy   receiver is inside a frame
// Modports: master drives the line and consumes the byte, slave is the receiver.
interface receiver_if;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport master (
    output rx,
    output clken,
    output rdy_clr,
    input  data,
    input  rdy,
    input  frame_err,
    input  overrun,
    input  rx_busy
  );

  modport slave (
    input  rx,
    input  clken,
    input  rdy_clr,
    output data,
    output rdy,
    output frame_err,
    output overrun,
    output rx_busy
  );
endinterface

// File: rtl/receiver.sv
// 8N1 UART receive stage.
// The serial line is double-synchronized, a start bit is qualified at mid-bit, the eight data
// bits are sampled at mid-bit LSB first, and the stop bit is checked at mid-bit. A good frame
// commits the byte with a ready flag; a low stop bit raises a framing error instead.
// Ports:
//   clk_50m  system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      receiver_if.slave: rx, clken, rdy_clr in; data, rdy, frame_err, overrun,
//            rx_busy out
// Parameter OVERSAMPLE: clken ticks per bit period, even and at least 4.
module receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic       clk_50m,
  input logic       rst_n,
  receiver_if.slave bus
);

  localparam int unsigned SampleW = $clog2(OVERSAMPLE);
  localparam logic [SampleW-1:0] HalfLast = SampleW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampleW-1:0] FullLast = SampleW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  state_e             state_q;
  logic               rx_meta_q;
  logic               rx_s_q;
  logic               armed_q;
  logic [SampleW-1:0] sample_q;
  logic [2:0]         bitpos_q;
  logic [7:0]         scratch_q;
  logic [7:0]         data_q;
  logic               rdy_q;
  logic               frame_err_q;
  logic               overrun_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizer resets to the idle line level so no edge is seen on release.
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      sample_q    <= '0;
      bitpos_q    <= 3'd0;
      scratch_q   <= 8'h00;
      data_q      <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;

      // Acknowledge acts on any cycle; a commit later in this block overrides it.
      if (bus.rdy_clr) begin
        rdy_q       <= 1'b0;
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end

      if (bus.clken) begin
        case (state_q)
          StIdle: begin
            // Only a line seen high first may start a frame, so a reset in the middle of a
            // frame cannot mistake a low data bit for a start bit.
            if (rx_s_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q  <= StStart;
              sample_q <= '0;
            end
          end

          StStart: begin
            if (sample_q == HalfLast) begin
              sample_q <= '0;
              if (!rx_s_q) begin
                state_q  <= StData;
                bitpos_q <= 3'd0;
              end else begin
                // Too short to be a start bit.
                state_q <= StIdle;
              end
            end else begin
              sample_q <= sample_q + SampleW'(1);
            end
          end

          StData: begin
            if (sample_q == FullLast) begin
              scratch_q[bitpos_q] <= rx_s_q;
              sample_q            <= '0;
              if (bitpos_q == 3'd7) begin
                state_q <= StStop;
              end else begin
                bitpos_q <= bitpos_q + 3'd1;
              end
            end else begin
              sample_q <= sample_q + SampleW'(1);
            end
          end

          StStop: begin
            if (sample_q == FullLast) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              state_q  <= StIdle;
              sample_q <= '0;
              armed_q  <= 1'b1;
              if (rx_s_q) begin
                data_q      <= scratch_q;
                rdy_q       <= 1'b1;
                frame_err_q <= 1'b0;
                if (rdy_q && !bus.rdy_clr) begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              sample_q <= sample_q + SampleW'(1);
            end
          end

          default: begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            sample_q    <= '0;
            bitpos_q    <= 3'd0;
            scratch_q   <= 8'h00;
            data_q      <= 8'h00;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_receiver.sv
`timescale 1ns/1ps
module tb_receiver;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  logic clken_q = 1'b0;
  logic rx      = 1'b1;
  logic rdy_clr = 1'b0;
  int unsigned div_cnt = 0;
  int unsigned checks  = 0;
  int unsigned errors  = 0;

  receiver_if bus ();

  assign bus.rx      = rx;
  assign bus.clken   = clken_q;
  assign bus.rdy_clr = rdy_clr;

  receiver #(.OVERSAMPLE(16)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #10 clk_50m = ~clk_50m;

  // clken once every 27 clocks: 50 MHz / 27 / 16 ~= 115200 baud.
  always @(posedge clk_50m) begin
    if (div_cnt == 26) begin
      div_cnt <= 0;
      clken_q <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      clken_q <= 1'b0;
    end
  end

  // Returns on a rising edge at which the DUT samples clken high.
  task automatic wait_tick();
    @(posedge clk_50m);
    while (clken_q !== 1'b1) @(posedge clk_50m);
  endtask

  // Drives one frame; the stop bit lasts stop_ticks clken periods. With clr_at_commit the
  // acknowledge is held high for exactly the clock that samples the mid stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_ticks,
                            input bit clr_at_commit);
    wait_tick();
    @(negedge clk_50m) rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) wait_tick();
      @(negedge clk_50m) rx = b[i];
    end
    repeat (16) wait_tick();
    @(negedge clk_50m) rx = stop_val;
    for (int t = 1; t <= stop_ticks; t++) begin
      if (clr_at_commit && t == 9) begin
        repeat (26) @(posedge clk_50m);
        @(negedge clk_50m) rdy_clr = 1'b1;
        @(posedge clk_50m);
        @(negedge clk_50m) rdy_clr = 1'b0;
      end else begin
        wait_tick();
      end
    end
    @(negedge clk_50m) rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m) rdy_clr = 1'b1;
    @(negedge clk_50m) rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    checks++; if (bus.data !== 8'h00) begin errors++;
      $display("FAIL reset_data: got %h want 00", bus.data); end
    checks++; if (bus.rdy !== 1'b0) begin errors++;
      $display("FAIL reset_rdy: got %b want 0", bus.rdy); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++;
      $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL reset_rx_busy: got %b want 0", bus.rx_busy); end
    @(negedge clk_50m) rst_n = 1'b1;
  endtask

  task automatic test_good_byte();
    send_frame(8'h55, 1'b1, 16, 1'b0);
    checks++; if (bus.data !== 8'h55) begin errors++;
      $display("FAIL good_data: got %h want 55", bus.data); end
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL good_rdy: got %b want 1", bus.rdy); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++;
      $display("FAIL good_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL good_overrun: got %b want 0", bus.overrun); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL good_rx_busy: got %b want 0", bus.rx_busy); end
  endtask

  task automatic test_glitch();
    pulse_clr();
    checks++; if (bus.rdy !== 1'b0) begin errors++;
      $display("FAIL clr_rdy: got %b want 0", bus.rdy); end
    wait_tick();
    @(negedge clk_50m) rx = 1'b0;
    repeat (4) wait_tick();
    @(negedge clk_50m) rx = 1'b1;
    checks++; if (bus.rx_busy !== 1'b1) begin errors++;
      $display("FAIL glitch_busy_during: got %b want 1", bus.rx_busy); end
    repeat (12) wait_tick();
    @(negedge clk_50m);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL glitch_busy_after: got %b want 0", bus.rx_busy); end
    checks++; if (bus.rdy !== 1'b0) begin errors++;
      $display("FAIL glitch_rdy: got %b want 0", bus.rdy); end
    checks++; if (bus.data !== 8'h55) begin errors++;
      $display("FAIL glitch_data: got %h want 55", bus.data); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h11, 1'b1, 16, 1'b0);
    checks++; if (bus.data !== 8'h11) begin errors++;
      $display("FAIL fe_prior_data: got %h want 11", bus.data); end
    // Stop bit low for most of its period, then the line returns to idle.
    send_frame(8'hA3, 1'b0, 12, 1'b0);
    checks++; if (bus.frame_err !== 1'b1) begin errors++;
      $display("FAIL fe_flag: got %b want 1", bus.frame_err); end
    checks++; if (bus.data !== 8'h11) begin errors++;
      $display("FAIL fe_data_kept: got %h want 11", bus.data); end
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL fe_rdy_kept: got %b want 1", bus.rdy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL fe_overrun: got %b want 0", bus.overrun); end
    repeat (20) wait_tick();
    @(negedge clk_50m);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL fe_idle_after: got %b want 0", bus.rx_busy); end
    send_frame(8'h7E, 1'b1, 16, 1'b0);
    checks++; if (bus.data !== 8'h7E) begin errors++;
      $display("FAIL fe_next_data: got %h want 7e", bus.data); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++;
      $display("FAIL fe_next_flag: got %b want 0", bus.frame_err); end
    // rdy was still set from 0x11, so this commit is an overrun.
    checks++; if (bus.overrun !== 1'b1) begin errors++;
      $display("FAIL fe_next_overrun: got %b want 1", bus.overrun); end
    pulse_clr();
  endtask

  task automatic test_overrun();
    send_frame(8'h01, 1'b1, 16, 1'b0);
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL ov_first_overrun: got %b want 0", bus.overrun); end
    send_frame(8'h80, 1'b1, 16, 1'b0);
    checks++; if (bus.data !== 8'h80) begin errors++;
      $display("FAIL ov_data: got %h want 80", bus.data); end
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL ov_rdy: got %b want 1", bus.rdy); end
    checks++; if (bus.overrun !== 1'b1) begin errors++;
      $display("FAIL ov_flag: got %b want 1", bus.overrun); end
    pulse_clr();
    checks++; if (bus.rdy !== 1'b0) begin errors++;
      $display("FAIL ov_clr_rdy: got %b want 0", bus.rdy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL ov_clr_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_collision();
    send_frame(8'h5A, 1'b1, 16, 1'b0);
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL col_pre_rdy: got %b want 1", bus.rdy); end
    send_frame(8'h3C, 1'b1, 16, 1'b1);
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL col_rdy: got %b want 1", bus.rdy); end
    checks++; if (bus.data !== 8'h3C) begin errors++;
      $display("FAIL col_data: got %h want 3c", bus.data); end
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL col_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit busy_seen;
    b = 8'hF0;
    busy_seen = 1'b0;
    wait_tick();
    @(negedge clk_50m) rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (16) wait_tick();
      @(negedge clk_50m) rx = b[i];
    end
    repeat (8) wait_tick();
    @(negedge clk_50m) rst_n = 1'b0;
    #1;
    checks++; if (bus.data !== 8'h00) begin errors++;
      $display("FAIL mid_rst_data: got %h want 00", bus.data); end
    checks++; if (bus.rdy !== 1'b0) begin errors++;
      $display("FAIL mid_rst_rdy: got %b want 0", bus.rdy); end
    checks++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin errors++;
      $display("FAIL mid_rst_flags: got fe=%b ov=%b want 0 0", bus.frame_err, bus.overrun); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL mid_rst_busy: got %b want 0", bus.rx_busy); end
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_tick();
      @(negedge clk_50m);
      if (bus.rx_busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin errors++;
      $display("FAIL mid_rst_no_start: got busy_seen=%b want 0", busy_seen); end
    checks++; if (bus.rdy !== 1'b0) begin errors++;
      $display("FAIL mid_rst_no_rdy: got %b want 0", bus.rdy); end
    @(negedge clk_50m) rx = 1'b1;
    repeat (2) wait_tick();
    send_frame(8'hC3, 1'b1, 16, 1'b0);
    checks++; if (bus.data !== 8'hC3) begin errors++;
      $display("FAIL mid_rst_next_data: got %h want c3", bus.data); end
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL mid_rst_next_rdy: got %b want 1", bus.rdy); end
  endtask

  task automatic test_loopback();
    pulse_clr();
    send_frame(8'h9A, 1'b1, 16, 1'b0);
    checks++; if (bus.data !== 8'h9A) begin errors++;
      $display("FAIL loop_data: got %h want 9a", bus.data); end
    checks++; if (bus.rdy !== 1'b1) begin errors++;
      $display("FAIL loop_rdy: got %b want 1", bus.rdy); end
    checks++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin errors++;
      $display("FAIL loop_flags: got fe=%b ov=%b want 0 0", bus.frame_err, bus.overrun); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL loop_busy: got %b want 0", bus.rx_busy); end
  endtask

  initial begin
    #1_800_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within 1.8 ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_collision();
    test_reset_mid_frame();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- 8N1 UART receive stage. It consumes the serial line driven by the `transmitter` block in loopback, or by an external host.
- Samples the line on a 16x-oversampled clock enable and qualifies the start bit at mid-bit.
- Assembles the byte LSB-first and presents it with a ready flag, a framing-error flag and an overrun flag to downstream logic.
- Runs in the same `clk_50m` domain as `transmitter`; the baud-enable generator feeds both blocks.

Parameters:
- OVERSAMPLE, 16, number of `clken` ticks per bit period. Must be even and ≥4.

Ports:
- clk_50m  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous to clk_50m, idle high
- clken  in  1  single-cycle pulse at OVERSAMPLE x baud rate
- rdy_clr  in  1  consumer acknowledge; clears rdy and overrun
- data  out  8  last good received byte
- rdy  out  1  a byte is available in data
- frame_err  out  1  last frame had a low stop bit
- overrun  out  1  a byte was committed while rdy was still set
- rx_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async assert, sync deassert by the system):
  - data=0x00, rdy=0, frame_err=0, overrun=0, rx_busy=0.
  - State=IDLE, armed=0, sample=0, bitpos=0, scratch=0x00.
  - Both synchronizer flops = 1.
- Synchronizer: rx passes through 2 flops to produce rx_s. All decisions use rx_s only.
- sample counter and state transitions advance only on cycles where clken=1. Flag updates from rdy_clr occur on any cycle.
- IDLE:
  - On clken with rx_s=1: armed<=1.
  - On clken with armed=1 and rx_s=0: go to START, sample<=0.
  - While armed=0, a low line is ignored. This prevents false starts after a reset mid-frame.
- START, on clken:
  - If sample==OVERSAMPLE/2-1: if rx_s=0, go to DATA with sample<=0 and bitpos<=0. If rx_s=1, it is a glitch: return to IDLE with no flag change.
  - Else sample<=sample+1.
- DATA, on clken:
  - If sample==OVERSAMPLE-1: scratch[bitpos]<=rx_s and sample<=0. If bitpos==7 go to STOP, else bitpos<=bitpos+1.
  - Else sample<=sample+1.
  - Bits are sampled at mid-bit, LSB first.
- STOP, on clken with sample==OVERSAMPLE-1, then go to IDLE with sample<=0 and armed<=1:
  - rx_s=1 (good frame): data<=scratch, rdy<=1, frame_err<=0. overrun<=1 if rdy=1 and rdy_clr=0 in that cycle.
  - rx_s=0 (bad frame): frame_err<=1; data, rdy and overrun are unchanged.
  - Otherwise sample<=sample+1.
- The block returns to IDLE at mid stop bit, so a back-to-back start bit is caught with no idle gap required.
- rdy_clr:
  - Clears rdy, overrun and frame_err one cycle later (registered).
  - If a good-frame commit occurs in the same cycle, the commit wins: rdy=1. overrun is not set by that commit.
- rx_busy: combinational from state, (state!=IDLE).
- Latency: rdy rises on the clk_50m edge after the mid-stop-bit clken sample. That is 9.5 bit periods after the start falling edge, plus 2 cycles of synchronizer delay and up to 1 clken of start-detect jitter.
- Reset mid-frame: the partial byte is discarded and no flag is raised. The block stays disarmed until rx_s is high on a clken.
- Unreachable state encodings recover to IDLE with the same settings as reset.

Test Plan:
- **Good byte:** clk_50m 50 MHz, clken every 27 cycles; send 0x55 at 115200 baud on rx → data=0x55, rdy=1, frame_err=0, overrun=0; rx_busy low after mid stop bit.
- **Glitch rejection:** drive rx low for 4 clken ticks then high → state returns to IDLE, rdy stays 0, data unchanged.
- **Framing error:** send 0xA3 with the stop bit forced low, after a prior good 0x11 → frame_err=1, data=0x11, rdy unchanged. A following good 0x7E gives data=0x7E and frame_err=0.
- **Overrun:** send 0x01 then 0x80 back-to-back with no rdy_clr → data=0x80, rdy=1, overrun=1. Pulse rdy_clr → rdy=0, overrun=0 next cycle.
- **Clear/commit collision:** assert rdy_clr in exactly the commit cycle of 0x3C → rdy=1, data=0x3C, overrun=0.
- **Reset mid-frame:**
  - Assert rst_n=0 during bit 3 of 0xF0 → all outputs 0 immediately.
  - Release with rx held low → no start detected.
  - Return rx high, then send 0xC3 → data=0xC3, rdy=1.
  - Repeat the good-byte case in loopback from transmitter with din=0x9A → data=0x9A.
